tx_src_arbiter: RTL and testbench

TX_SRC_ARBITER -- requirements
Module: tx_src_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_picker.sv | 34 +++
 rtl/tx_src_arbiter.sv | 136 +++++++++++++
 tb/tb_tx_src_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: source-arbiter state and arbitration mode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_FULL,
    ST_DELIVER
  } arb_state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational next-source search: round-robin from last+1, or lowest index first.
module rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDW     = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  input  arb_mode_e          mode_i,
  output logic               found_o,
  output logic [IDW-1:0]     pick_o
);

  int unsigned base;
  int unsigned cand;

  always_comb begin
    found_o = 1'b0;
    pick_o  = '0;
    base    = (mode_i == ARB_FIXED) ? 32'd0 : 32'(last_i) + 32'd1;
    cand    = 32'd0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      // base never exceeds NUM_SRC, so a single subtraction wraps the index
      cand = base + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found_o && req_i[cand[IDW-1:0]]) begin
        found_o = 1'b1;
        pick_o  = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_src_arbiter.sv
// Arbitrates several byte sources into a single FIFO-like read port for the TX engine.
module tx_src_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       en_i,
  input  logic                       arb_mode_i,
  input  logic [NUM_SRC-1:0]         src_empty_i,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  input  logic [NUM_SRC*8-1:0]       src_data_i,
  output logic [NUM_SRC-1:0]         src_ren_o,
  input  logic                       tx_fifo_ren_i,
  output logic                       tx_fifo_empty_o,
  output logic                       tx_fifo_valid_o,
  output logic [7:0]                 tx_fifo_data_o,
  output logic [$clog2(NUM_SRC)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic                       timeout_err_o
);

  localparam int unsigned IDW = $clog2(NUM_SRC);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_SRC - 1);
  localparam logic [TW-1:0]  TCNT_END = TW'(TIMEOUT_CYC - 1);

  arb_state_e           state_q;
  logic [IDW-1:0]       last_q;
  logic [IDW-1:0]       grant_q;
  logic [TW-1:0]        tcnt_q;
  logic [7:0]           hold_q;
  logic [NUM_SRC-1:0]   ren_q;
  logic                 empty_q;
  logic                 valid_q;
  logic [7:0]           data_q;
  logic                 busy_q;
  logic                 terr_q;

  logic                 pick_found;
  logic [IDW-1:0]       pick_idx;
  logic                 grant_valid;
  logic [7:0]           grant_byte;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_picker (
    .req_i   (~src_empty_i),
    .last_i  (last_q),
    .mode_i  (arb_mode_e'(arb_mode_i)),
    .found_o (pick_found),
    .pick_o  (pick_idx)
  );

  assign grant_valid = src_valid_i[grant_q];
  assign grant_byte  = src_data_i[{grant_q, 3'b000} +: 8];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      tcnt_q  <= '0;
      hold_q  <= '0;
      ren_q   <= '0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      ren_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (en_i && pick_found) begin
            grant_q         <= pick_idx;
            ren_q[pick_idx] <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          tcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (grant_valid) begin
            hold_q  <= grant_byte;
            last_q  <= grant_q;
            empty_q <= 1'b0;
            state_q <= ST_FULL;
          end else if (tcnt_q == TCNT_END) begin
            // advancing the pointer past a dead source keeps it from starving the rest
            terr_q  <= 1'b1;
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        ST_FULL: begin
          if (tx_fifo_ren_i) begin
            data_q  <= hold_q;
            valid_q <= 1'b1;
            empty_q <= 1'b1;
            state_q <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          empty_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_ren_o       = ren_q;
  assign tx_fifo_empty_o = empty_q;
  assign tx_fifo_valid_o = valid_q;
  assign tx_fifo_data_o  = data_q;
  assign grant_id_o      = grant_q;
  assign busy_o          = busy_q;
  assign timeout_err_o   = terr_q;

endmodule

// File: tb/tb_tx_src_arbiter.sv
// Self-checking bench for tx_src_arbiter: behavioural reference model, scripted and random stimulus.
module tb_tx_src_arbiter;

  localparam int N   = 2;
  localparam int TO  = 15;
  localparam int IDW = $clog2(N);

  localparam int ST_I = 0, ST_F = 1, ST_W = 2, ST_FULL = 3, ST_D = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               mode = 1'b0;
  logic               ren = 1'b0;
  logic [N-1:0]       src_empty = '1;
  logic [N-1:0]       src_valid = '0;
  logic [N*8-1:0]     src_data = '0;
  logic [N-1:0]       src_ren_o;
  logic               tx_fifo_empty_o;
  logic               tx_fifo_valid_o;
  logic [7:0]         tx_fifo_data_o;
  logic [IDW-1:0]     grant_id_o;
  logic               busy_o;
  logic               timeout_err_o;

  tx_src_arbiter #(
    .NUM_SRC     (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .en_i            (en),
    .arb_mode_i      (mode),
    .src_empty_i     (src_empty),
    .src_valid_i     (src_valid),
    .src_data_i      (src_data),
    .src_ren_o       (src_ren_o),
    .tx_fifo_ren_i   (ren),
    .tx_fifo_empty_o (tx_fifo_empty_o),
    .tx_fifo_valid_o (tx_fifo_valid_o),
    .tx_fifo_data_o  (tx_fifo_data_o),
    .grant_id_o      (grant_id_o),
    .busy_o          (busy_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 clk = ~clk;

  // source FIFOs: byte queues, read latency in cycles, silent sources never answer
  logic [7:0] srcq [N][$];
  int         lat [N];
  bit         silent [N];
  int         pcnt [N];
  logic [7:0] pbyte [N];
  bit         noise_on;
  logic [N-1:0]   ren_seen;
  logic [N-1:0]   n_empty, n_valid;
  logic [N*8-1:0] n_data;

  // reference model
  int         m_stage, m_grant, m_last, m_wcnt;
  logic [7:0] m_hold;
  logic [N-1:0] e_ren;
  bit         e_empty, e_valid, e_busy, e_terr;
  logic [7:0] e_data;
  int         e_grant;
  logic [7:0] m_out [$];

  // observations of the DUT
  logic [7:0] obs_out [$];
  int         cycle, obs_ren_cnt, obs_ren01, obs_to, ren1_cycle, to_cycle;
  logic [N-1:0] first_after_to;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_rr [6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
  logic [7:0] exp_fp [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] nonempty, input bit fixed, input int last);
    for (int off = 0; off < N; off++) begin
      int k;
      k = fixed ? off : (last + 1 + off) % N;
      if (nonempty[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = ST_I; m_last = N - 1; m_grant = 0; m_wcnt = 0; m_hold = '0;
    e_ren = '0; e_empty = 1'b1; e_valid = 1'b0; e_data = '0; e_grant = 0;
    e_busy = 1'b0; e_terr = 1'b0;
  endtask

  task automatic model_step();
    int k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_terr = 1'b0; e_ren = '0; e_valid = 1'b0;
    case (m_stage)
      ST_I: if (en) begin
        k = model_pick(~src_empty, mode, m_last);
        if (k >= 0) begin
          m_grant = k; e_grant = k; e_ren[k] = 1'b1; e_busy = 1'b1; m_stage = ST_F;
        end
      end
      ST_F: begin m_stage = ST_W; m_wcnt = 0; end
      ST_W: begin
        if (src_valid[m_grant]) begin
          m_hold = src_data[8*m_grant +: 8]; m_last = m_grant; e_empty = 1'b0; m_stage = ST_FULL;
        end else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            e_terr = 1'b1; m_last = m_grant; e_busy = 1'b0; m_stage = ST_I;
          end
        end
      end
      ST_FULL: if (ren) begin
        e_valid = 1'b1; e_data = m_hold; e_empty = 1'b1; m_stage = ST_D;
        m_out.push_back(m_hold);
      end
      default: begin e_busy = 1'b0; m_stage = ST_I; end
    endcase
  endtask

  task automatic src_step();
    for (int k = 0; k < N; k++) begin
      if (!rst_n) pcnt[k] = 0;
      else if (ren_seen[k]) begin
        if (srcq[k].size() != 0) pbyte[k] = srcq[k].pop_front();
        pcnt[k] = silent[k] ? 0 : lat[k];
      end
      n_valid[k] = (pcnt[k] == 1);
      n_data[8*k +: 8] = pbyte[k];
      if (pcnt[k] > 0) pcnt[k]--;
      if (noise_on && !n_valid[k] && m_stage == ST_W && k != m_grant && $urandom_range(0, 3) == 0) begin
        n_valid[k] = 1'b1;
        n_data[8*k +: 8] = 8'($urandom);
      end
      n_empty[k] = (srcq[k].size() == 0);
    end
  endtask

  task automatic compare_cycle();
    cycle++;
    check("src_ren", 32'(src_ren_o), 32'(e_ren));
    check("tx_empty", 32'(tx_fifo_empty_o), 32'(e_empty));
    check("tx_valid", 32'(tx_fifo_valid_o), 32'(e_valid));
    check("tx_data", 32'(tx_fifo_data_o), 32'(e_data));
    check("grant_id", 32'(grant_id_o), 32'(e_grant));
    check("busy", 32'(busy_o), 32'(e_busy));
    check("timeout_err", 32'(timeout_err_o), 32'(e_terr));
    if (tx_fifo_valid_o) obs_out.push_back(tx_fifo_data_o);
    if (src_ren_o != '0) begin
      obs_ren_cnt++;
      if (obs_to > 0 && first_after_to == '0) first_after_to = src_ren_o;
    end
    if (src_ren_o == 2'b01) obs_ren01++;
    if (src_ren_o[1]) ren1_cycle = cycle;
    if (timeout_err_o) begin obs_to++; to_cycle = cycle; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    src_step();
    #2;
    src_empty = n_empty; src_valid = n_valid; src_data = n_data;
    @(negedge clk);
    compare_cycle();
    ren_seen = src_ren_o;
  endtask

  task automatic clear_obs();
    obs_out.delete(); m_out.delete();
    obs_ren_cnt = 0; obs_ren01 = 0; obs_to = 0; ren1_cycle = 0; to_cycle = 0;
    first_after_to = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; ren = 1'b0; mode = 1'b0; noise_on = 1'b0; ren_seen = '0;
    for (int k = 0; k < N; k++) begin
      srcq[k].delete(); lat[k] = 1; silent[k] = 1'b0; pcnt[k] = 0; pbyte[k] = '0;
    end
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic run_until_out(input string nm, input int n, input int budget, input bit rand_ren);
    int c = 0;
    while (m_out.size() < n && c < budget) begin
      if (rand_ren) ren = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    ren = 1'b0;
    check(nm, 32'(m_out.size() >= n), 32'd1);
  endtask

  task automatic wait_full(input string nm, input int budget);
    int c = 0;
    while (tx_fifo_empty_o && c < budget) begin tick(); c++; end
    check(nm, 32'(tx_fifo_empty_o), 32'd0);
  endtask

  initial begin
    cycle = 0;
    do_reset();
    check("reset_empty", 32'(tx_fifo_empty_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_grant", 32'(grant_id_o), 32'd0);
    check("reset_data", 32'(tx_fifo_data_o), 32'd0);

    // single source, one byte
    srcq[0].push_back(8'hA5); lat[0] = 2; en = 1'b1;
    wait_full("s1_full", 40);
    check("s1_ren_cycles", 32'(obs_ren_cnt), 32'd1);
    check("s1_ren01", 32'(obs_ren01), 32'd1);
    ren = 1'b1; tick(); ren = 1'b0;
    check("s1_valid", 32'(tx_fifo_valid_o), 32'd1);
    check("s1_data", 32'(tx_fifo_data_o), 32'hA5);
    check("s1_grant", 32'(grant_id_o), 32'd0);
    tick();
    check("s1_valid_drop", 32'(tx_fifo_valid_o), 32'd0);
    check("s1_data_hold", 32'(tx_fifo_data_o), 32'hA5);

    // round-robin then fixed-priority ordering
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mode = 1'(pass); en = 1'b1; noise_on = 1'b1;
      for (int b = 0; b < 3; b++) begin
        srcq[0].push_back(8'h10 + 8'(b)); srcq[1].push_back(8'h20 + 8'(b));
      end
      lat[0] = 3; lat[1] = 1;
      run_until_out(pass ? "fp_budget" : "rr_budget", 6, 400, 1'b1);
      check(pass ? "fp_count" : "rr_count", 32'(obs_out.size()), 32'd6);
      for (int i = 0; i < 6 && i < obs_out.size() && i < m_out.size(); i++) begin
        check($sformatf("%s_dut_%0d", pass ? "fp" : "rr", i), 32'(obs_out[i]), 32'(pass ? exp_fp[i] : exp_rr[i]));
        check($sformatf("%s_model_%0d", pass ? "fp" : "rr", i), 32'(m_out[i]), 32'(pass ? exp_fp[i] : exp_rr[i]));
      end
    end

    // silent source times out, other source is served next
    begin
      int c;
      do_reset();
      en = 1'b1; silent[1] = 1'b1;
      srcq[1].push_back(8'h66); srcq[1].push_back(8'h67);
      c = 0;
      while (ren1_cycle == 0 && c < 20) begin tick(); c++; end
      check("to_src1_fetched", 32'(ren1_cycle != 0), 32'd1);
      srcq[0].push_back(8'h55); lat[0] = 3;
      c = 0;
      while (obs_to == 0 && c < 40) begin tick(); c++; end
      check("to_pulse_seen", 32'(obs_to), 32'd1);
      check("to_latency", 32'(to_cycle - ren1_cycle), 32'd16);
      run_until_out("to_budget", 1, 40, 1'b1);
      check("to_count_at_deliver", 32'(obs_to), 32'd1);
      check("to_next_grant", 32'(first_after_to), 32'b01);
      en = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      check("to_deliver_count", 32'(obs_out.size()), 32'd1);
      if (obs_out.size() > 0) check("to_deliver_byte", 32'(obs_out[0]), 32'h55);
    end

    // reset while FULL discards the held byte
    do_reset();
    en = 1'b1; srcq[0].push_back(8'h3C); lat[0] = 1;
    wait_full("rst_full", 40);
    rst_n = 1'b0; ren_seen = '0;
    #1;
    check("rst_empty_now", 32'(tx_fifo_empty_o), 32'd1);
    check("rst_busy_now", 32'(busy_o), 32'd0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1; ren = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ren = 1'b0;
    check("rst_no_valid", 32'(obs_out.size()), 32'd0);

    // en_i dropped mid-fetch: byte completes, no further grants
    begin
      int c;
      do_reset();
      en = 1'b1; srcq[0].push_back(8'h77); lat[0] = 4; srcq[1].push_back(8'h88); lat[1] = 1;
      c = 0;
      while (m_stage != ST_W && c < 20) begin tick(); c++; end
      en = 1'b0; obs_ren_cnt = 0; ren = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      ren = 1'b0;
      check("en_count", 32'(obs_out.size()), 32'd1);
      if (obs_out.size() > 0) check("en_byte", 32'(obs_out[0]), 32'h77);
      check("en_no_ren", 32'(obs_ren_cnt), 32'd0);
    end

    // randomized traffic against the model
    do_reset();
    noise_on = 1'b1; en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      ren = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0 && srcq[k].size() < 4) srcq[k].push_back(8'($urandom));
        lat[k] = $urandom_range(1, 17);
        silent[k] = ($urandom_range(0, 19) == 0);
      end
      tick();
    end
    check("rand_count", 32'(obs_out.size()), 32'(m_out.size()));
    for (int i = 0; i < obs_out.size() && i < m_out.size(); i++)
      check($sformatf("rand_byte_%0d", i), 32'(obs_out[i]), 32'(m_out[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
